// File: rtl/wallace_mac_unit.sv
`default_nettype none
// ============================================================================
// Module   : wallace_mac_unit  (plus WallaceTree, wallace_csa_level)
// Purpose  : Two-stage multiply-accumulate around a 16x16 Wallace-tree
//            multiplier. Operand beats arrive over valid/ready. Their
//            32-bit products are summed across a group closed by in_last_i.
//            Each group result is held in an output register with
//            valid/ready backpressure.
// Ports    : clk, rst_n (async, active-low)
//            in_valid_i/in_ready_o, in_a_i, in_b_i, in_clr_i, in_last_i
//            out_valid_o/out_ready_i, out_data_o[ACC_W], out_count_o[CNT_W],
//            out_ovf_o
// Revision : 1.0 - initial release
// ============================================================================

// ----------------------------------------------------------------------------
// One 3:2 carry-save reduction level. Rows are taken in groups of three and
// each group becomes a sum row and a carry row. Rows left over after the
// last complete group pass straight through.
// ----------------------------------------------------------------------------
module wallace_csa_level #(
    parameter int N_IN  = 16,
    parameter int N_OUT = 11,
    parameter int W     = 32
) (
    input  logic [N_IN-1:0][W-1:0]  rows_i,
    output logic [N_OUT-1:0][W-1:0] rows_o
);
    localparam int c_N_GRP  = N_IN / 3;
    localparam int c_N_PASS = N_IN % 3;

    for (genvar g = 0; g < c_N_GRP; g++) begin : g_csa
        assign rows_o[2*g]   = rows_i[3*g] ^ rows_i[3*g+1] ^ rows_i[3*g+2];
        // The carry moves one column left. Bit W-1 is dropped: the final
        // product fits in W bits, so arithmetic modulo 2^W stays exact.
        assign rows_o[2*g+1] = {(rows_i[3*g][W-2:0]   & rows_i[3*g+1][W-2:0]) |
                                (rows_i[3*g][W-2:0]   & rows_i[3*g+2][W-2:0]) |
                                (rows_i[3*g+1][W-2:0] & rows_i[3*g+2][W-2:0]),
                                1'b0};
    end

    for (genvar p = 0; p < c_N_PASS; p++) begin : g_pass
        assign rows_o[2*c_N_GRP+p] = rows_i[3*c_N_GRP+p];
    end
endmodule

// ----------------------------------------------------------------------------
// Combinational unsigned 16x16 -> 32 Wallace-tree multiplier.
// The rows are reduced 16 -> 11 -> 8 -> 6 -> 4 -> 3 -> 2, and one adder
// produces the final result.
// ----------------------------------------------------------------------------
module WallaceTree (
    input  logic [15:0] a,
    input  logic [15:0] b,
    output logic [31:0] out
);
    logic [15:0][31:0] w_pp;
    logic [10:0][31:0] w_l1;
    logic [7:0][31:0]  w_l2;
    logic [5:0][31:0]  w_l3;
    logic [3:0][31:0]  w_l4;
    logic [2:0][31:0]  w_l5;
    logic [1:0][31:0]  w_l6;

    for (genvar i = 0; i < 16; i++) begin : g_pp
        assign w_pp[i] = b[i] ? ({16'd0, a} << i) : 32'd0;
    end

    wallace_csa_level #(.N_IN(16), .N_OUT(11), .W(32)) u_l1 (.rows_i(w_pp), .rows_o(w_l1));
    wallace_csa_level #(.N_IN(11), .N_OUT(8),  .W(32)) u_l2 (.rows_i(w_l1), .rows_o(w_l2));
    wallace_csa_level #(.N_IN(8),  .N_OUT(6),  .W(32)) u_l3 (.rows_i(w_l2), .rows_o(w_l3));
    wallace_csa_level #(.N_IN(6),  .N_OUT(4),  .W(32)) u_l4 (.rows_i(w_l3), .rows_o(w_l4));
    wallace_csa_level #(.N_IN(4),  .N_OUT(3),  .W(32)) u_l5 (.rows_i(w_l4), .rows_o(w_l5));
    wallace_csa_level #(.N_IN(3),  .N_OUT(2),  .W(32)) u_l6 (.rows_i(w_l5), .rows_o(w_l6));

    assign out = w_l6[0] + w_l6[1];
endmodule

// ----------------------------------------------------------------------------
// Multiply-accumulate stage. ACC_W must be at least 32.
// ----------------------------------------------------------------------------
module wallace_mac_unit #(
    parameter int ACC_W = 40,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [15:0]      in_a_i,
    input  logic [15:0]      in_b_i,
    input  logic             in_clr_i,
    input  logic             in_last_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [ACC_W-1:0] out_data_o,
    output logic [CNT_W-1:0] out_count_o,
    output logic             out_ovf_o
);
    // Stage 1 operand register
    logic             s1_valid_q, s1_valid_d;
    logic [15:0]      s1_a_q, s1_a_d;
    logic [15:0]      s1_b_q, s1_b_d;
    logic             s1_clr_q, s1_clr_d;
    logic             s1_last_q, s1_last_d;
    // Stage 2 running group state
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             acc_ovf_q, acc_ovf_d;
    // Output result register
    logic             out_valid_q, out_valid_d;
    logic [ACC_W-1:0] out_data_q, out_data_d;
    logic [CNT_W-1:0] out_count_q, out_count_d;
    logic             out_ovf_q, out_ovf_d;

    logic [31:0]      w_prod;
    logic             w_s1_adv;
    logic             w_accept;
    logic [ACC_W-1:0] w_base;
    logic [ACC_W:0]   w_sum;
    logic [CNT_W-1:0] w_nc;
    logic             w_no;

    WallaceTree u_mult (
        .a   (s1_a_q),
        .b   (s1_b_q),
        .out (w_prod)
    );

    // Only a last beat can stall, and only when the output register is
    // occupied and not draining this cycle.
    assign w_s1_adv   = s1_valid_q && (!s1_last_q || !out_valid_q || out_ready_i);
    assign in_ready_o = !s1_valid_q || w_s1_adv;
    assign w_accept   = in_valid_i && in_ready_o;

    // in_clr restarts the group at this beat. The sum carries one extra bit
    // so an overflow out of ACC_W can be seen.
    assign w_base = s1_clr_q ? '0 : acc_q;
    assign w_sum  = {1'b0, w_base} + {{(ACC_W+1-32){1'b0}}, w_prod};
    assign w_nc   = (s1_clr_q ? '0 : cnt_q) + {{(CNT_W-1){1'b0}}, 1'b1};
    assign w_no   = (s1_clr_q ? 1'b0 : acc_ovf_q) | w_sum[ACC_W];

    always_comb begin
        s1_valid_d  = s1_valid_q;
        s1_a_d      = s1_a_q;
        s1_b_d      = s1_b_q;
        s1_clr_d    = s1_clr_q;
        s1_last_d   = s1_last_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        acc_ovf_d   = acc_ovf_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_count_d = out_count_q;
        out_ovf_d   = out_ovf_q;

        if (w_accept) begin
            s1_valid_d = 1'b1;
            s1_a_d     = in_a_i;
            s1_b_d     = in_b_i;
            s1_clr_d   = in_clr_i;
            s1_last_d  = in_last_i;
        end else if (w_s1_adv) begin
            s1_valid_d = 1'b0;
        end

        if (out_valid_q && out_ready_i) begin
            out_valid_d = 1'b0;
        end

        if (w_s1_adv) begin
            if (s1_last_q) begin
                // A result written here replaces one that is being consumed
                // in the same cycle. The group state auto-restarts.
                out_valid_d = 1'b1;
                out_data_d  = w_sum[ACC_W-1:0];
                out_count_d = w_nc;
                out_ovf_d   = w_no;
                acc_d       = '0;
                cnt_d       = '0;
                acc_ovf_d   = 1'b0;
            end else begin
                acc_d       = w_sum[ACC_W-1:0];
                cnt_d       = w_nc;
                acc_ovf_d   = w_no;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q  <= 1'b0;
            s1_a_q      <= '0;
            s1_b_q      <= '0;
            s1_clr_q    <= 1'b0;
            s1_last_q   <= 1'b0;
            acc_q       <= '0;
            cnt_q       <= '0;
            acc_ovf_q   <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_count_q <= '0;
            out_ovf_q   <= 1'b0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_a_q      <= s1_a_d;
            s1_b_q      <= s1_b_d;
            s1_clr_q    <= s1_clr_d;
            s1_last_q   <= s1_last_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            acc_ovf_q   <= acc_ovf_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_count_q <= out_count_d;
            out_ovf_q   <= out_ovf_d;
        end
    end

    assign out_valid_o = out_valid_q;
    assign out_data_o  = out_data_q;
    assign out_count_o = out_count_q;
    assign out_ovf_o   = out_ovf_q;
endmodule

`default_nettype wire

// File: doc/wallace_mac_unit.md
Name: wallace_mac_unit

Overview:
- Sequential multiply-accumulate stage wrapped around the team's combinational 16x16 Wallace tree multiplier (module WallaceTree, ports a, b, out).
- Accepts a stream of unsigned operand pairs over a valid/ready handshake and registers them into the multiplier's inputs.
- Accumulates the 32-bit products across a group of beats delimited by in_last.
- Presents each group's sum, beat count and overflow flag on a held output register with valid/ready backpressure.

Parameters:
- ACC_W, 40: accumulator and out_data width; must be ≥ 32. Product is zero-extended to ACC_W.
- CNT_W, 8: beat-counter width; out_count wraps modulo 2^CNT_W.

Ports:
- clk, input, 1: rising-edge clock.
- rst_n, input, 1: asynchronous, active-low reset; one clock; reset is asynchronous and active-low.
- in_valid, input, 1: operand beat valid.
- in_ready, output, 1: stage can accept a beat this cycle.
- in_a, input, 16: unsigned multiplicand.
- in_b, input, 16: unsigned multiplier.
- in_clr, input, 1: discard any partial group sum before adding this beat.
- in_last, input, 1: this beat closes the group.
- out_valid, output, 1: result register holds an unconsumed group result.
- out_ready, input, 1: consumer accepts the result.
- out_data, output, ACC_W: group sum of products.
- out_count, output, CNT_W: number of beats in the group, including the last beat.
- out_ovf, output, 1: accumulator carried out of ACC_W at any point in the group.

Behaviour:
- Reset (async, rst_n=0) clears the following registers immediately: s1_valid, s1_a, s1_b, s1_clr, s1_last, acc, cnt, acc_ovf, out_valid, out_data, out_count, out_ovf. All outputs read 0 while reset is held except in_ready, which reads 1.
- A reset mid-group or mid-hold drops all partial state; no result is emitted.

Stage 1 (operand register):
- Loads in_a, in_b, in_clr and in_last on an edge where in_valid && in_ready.
- s1_a and s1_b drive WallaceTree directly. prod = s1_a*s1_b, 32 bits, combinational.

Stage 2 (accumulate), advance condition:
- s1_adv = s1_valid && (!s1_last || !out_valid || out_ready).
- in_ready = !s1_valid || s1_adv. This allows full throughput, one beat per cycle.

Stage 2 update on an edge with s1_adv:
- base = s1_clr ? 0 : acc.
- sum = base + zext(prod), computed ACC_W+1 bits wide.
- nc = (s1_clr ? 0 : cnt) + 1.
- no = (s1_clr ? 0 : acc_ovf) | sum[ACC_W].
- If s1_last:
  - out_data <= sum[ACC_W-1:0]; out_count <= nc; out_ovf <= no; out_valid <= 1.
  - acc, cnt and acc_ovf are cleared (auto-restart for the next group).
- Else: acc <= sum; cnt <= nc; acc_ovf <= no.

Stage 1 drain without refill:
- If s1_adv is true and no new beat is accepted that cycle, s1_valid <= 0.

Output register:
- out_valid, out_data, out_count and out_ovf stay stable while out_valid && !out_ready.
- On out_valid && out_ready with no new last beat advancing, out_valid <= 0.
- If a last beat advances in the same cycle as the output handshake, the register is reloaded with the new result and out_valid stays 1.

Latency:
- A beat accepted at edge E0 is added at E1.
- For a last beat, out_valid rises after E1.

Stall:
- Only a last beat waits, and only while the output is full and not being drained.
- Non-last beats never stall.

Boundary cases:
- in_clr && in_last on the same beat yields a single-term result: out_data = prod, out_count = 1.
- in_clr mid-group discards the earlier partial sum, count and overflow.
- Multiplier extremes: 0xFFFF*0xFFFF = 0xFFFE0001, with no truncation.

Test Plan:
- Reset, then one beat a=3, b=5, last=1 with out_ready=1 → out_valid pulses 1 cycle after acceptance; out_data=15, out_count=1, out_ovf=0.
- Group of 4 back-to-back beats: (0xFFFF,0xFFFF)×3 followed by (2,7) with last → in_ready stays 1 throughout; out_data=0x2FFFA0011, out_count=4.
- Backpressure: two single-beat groups (10×10, 20×20) with out_ready=0 → first result 100 is held; the second last beat stalls with in_ready=0 on the following beat. Raising out_ready gives 100, then 400 on the next cycle, with no beat lost.
- Beats 4×4, 5×5, then in_clr with 6×6 and last → out_data=36, out_count=1.
- ACC_W=33, two beats of 0xFFFF×0xFFFF plus two more, last on the fourth → out_ovf=1 and out_data = true sum mod 2^33.
- Assert rst_n=0 mid-group after 2 beats, release, then send 1×1 with last → out_data=1, out_count=1; no stale output appears during or after reset.
